// File: rtl/cache_set_assoc_pkg.sv
// Shared constants and helpers for the set-associative cache set.
package cache_set_assoc_pkg;

    // Ceiling log2 for sizing index fields; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Default geometry and the index widths it implies.
    localparam int WAYS_DEF  = 4;
    localparam int WORDS_DEF = 4;
    localparam int OFF_W     = clog2(WORDS_DEF);
    localparam int WAY_W     = clog2(WAYS_DEF);

    // Line-fill state encoding.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

endpackage

// File: rtl/cache_set_assoc_if.sv
// CPU / controller-facing bus of the cache set. The controller drives the
// master side; the cache set is the slave.
interface cache_set_assoc_if
    import cache_set_assoc_pkg::*;
#(
    parameter int WAYS   = WAYS_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
);
    localparam int OFF_BITS = clog2(WORDS);
    localparam int WAY_BITS = clog2(WAYS);

    logic [OFF_BITS-1:0] Offset;
    logic [TAG_W-1:0]    ReqTag;
    logic                Access;
    logic                WE;
    logic [DATA_W-1:0]   WD;
    logic                Hit;
    logic [WAY_BITS-1:0] HitWay;
    logic [DATA_W-1:0]   RD;
    logic [WAY_BITS-1:0] VictimWay;
    logic                VictimDirty;
    logic [TAG_W-1:0]    VictimTag;
    logic [OFF_BITS-1:0] EvictOffset;
    logic [DATA_W-1:0]   EvictRD;
    logic                FillStart;
    logic                FillWE;
    logic [DATA_W-1:0]   FillWD;
    logic                FillBusy;
    logic                FillDone;

    modport master (
        output Offset, ReqTag, Access, WE, WD, EvictOffset, FillStart, FillWE, FillWD,
        input  Hit, HitWay, RD, VictimWay, VictimDirty, VictimTag, EvictRD, FillBusy, FillDone
    );

    modport slave (
        input  Offset, ReqTag, Access, WE, WD, EvictOffset, FillStart, FillWE, FillWD,
        output Hit, HitWay, RD, VictimWay, VictimDirty, VictimTag, EvictRD, FillBusy, FillDone
    );

endinterface

// File: rtl/cache_set_assoc_plru_tree.sv
// Tree pseudo-LRU state for one cache set. Nodes are heap-numbered
// (root = 1, children of n are 2n and 2n+1); bit = 0 points the victim left.
module cache_set_assoc_plru_tree
    import cache_set_assoc_pkg::*;
#(
    parameter  int WAYS     = WAYS_DEF,
    localparam int WAY_BITS = clog2(WAYS)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                TouchA,
    input  logic [WAY_BITS-1:0] TouchWayA,
    input  logic                TouchB,
    input  logic [WAY_BITS-1:0] TouchWayB,
    output logic [WAY_BITS-1:0] VictimWay
);

    logic [WAYS-1:1] bits_q;
    logic [WAYS-1:1] bits_d;
    int              node;

    // Point every node on the path to `way` at the opposite subtree.
    function automatic logic [WAYS-1:1] touch(input logic [WAYS-1:1] b,
                                              input logic [WAY_BITS-1:0] way);
        logic [WAYS-1:1] r;
        int n;
        r = b;
        n = 1;
        for (int l = WAY_BITS - 1; l >= 0; l--) begin
            r[n] = ~way[l];
            n    = 2 * n + (way[l] ? 1 : 0);
        end
        return r;
    endfunction

    // Walk from the root following the bits to the leaf that is the victim.
    always_comb begin
        node = 1;
        for (int l = 0; l < WAY_BITS; l++)
            node = 2 * node + (bits_q[node] ? 1 : 0);
        VictimWay = WAY_BITS'(node - WAYS);
    end

    // Next state: touch A first, then B, so B's path wins on shared nodes.
    always_comb begin
        bits_d = bits_q;
        if (TouchA) bits_d = touch(bits_d, TouchWayA);
        if (TouchB) bits_d = touch(bits_d, TouchWayB);
    end

    // PLRU bit register.
    always_ff @(posedge CLK) begin
        if (Reset) bits_q <= '0;
        else       bits_q <= bits_d;
    end

endmodule

// File: rtl/cache_set_assoc.sv
// N-way set-associative cache set: parallel tag compare, tree-PLRU
// replacement and a beat-counted line-fill sequencer.
module cache_set_assoc
    import cache_set_assoc_pkg::*;
#(
    parameter int WAYS   = WAYS_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input logic              CLK,
    input logic              Reset,
    cache_set_assoc_if.slave bus
);

    localparam int OFF_BITS = clog2(WORDS);
    localparam int WAY_BITS = clog2(WAYS);
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS - 1);

    logic [DATA_W-1:0]   data_q [WAYS][WORDS];
    logic [TAG_W-1:0]    tag_q  [WAYS];
    logic [WAYS-1:0]     valid_q;
    logic [WAYS-1:0]     dirty_q;
    logic [0:0]          state_q;
    logic [WAY_BITS-1:0] fw_q;
    logic [OFF_BITS-1:0] cnt_q;
    logic                done_q;

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim;
    logic [WAY_BITS-1:0] plru_victim;
    logic                busy;
    logic                touch_hit;
    logic                cpu_wr;
    logic                fill_go;
    logic                fill_beat;
    logic                fill_last;

    assign busy      = (state_q == FILL);
    assign touch_hit = bus.Access & hit;
    assign cpu_wr    = touch_hit & bus.WE;
    assign fill_go   = (state_q == IDLE) & bus.FillStart;
    assign fill_beat = busy & bus.FillWE;
    assign fill_last = fill_beat & (cnt_q == LAST_BEAT);

    // Parallel tag compare; tags are unique among valid ways, so at most one matches.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w] && (tag_q[w] == bus.ReqTag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    // Replacement choice: lowest invalid way, else PLRU; frozen on the fill way while filling.
    always_comb begin
        victim = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[w]) victim = WAY_BITS'(w);
        if (busy) victim = fw_q;
    end

    assign bus.Hit         = hit;
    assign bus.HitWay      = hit_way;
    assign bus.RD          = hit ? data_q[hit_way][bus.Offset] : '0;
    assign bus.VictimWay   = victim;
    assign bus.VictimDirty = dirty_q[victim] & valid_q[victim];
    assign bus.VictimTag   = tag_q[victim];
    assign bus.EvictRD     = data_q[victim][bus.EvictOffset];
    assign bus.FillBusy    = busy;
    assign bus.FillDone    = done_q;

    // Data and tag storage; deliberately not reset. The fill way is invalid,
    // so a CPU write and a fill beat never target the same way.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (cpu_wr)    data_q[hit_way][bus.Offset] <= bus.WD;
            if (fill_beat) data_q[fw_q][cnt_q]         <= bus.FillWD;
            if (fill_go)   tag_q[victim]               <= bus.ReqTag;
        end
    end

    // Valid/dirty bookkeeping and the IDLE/FILL sequencer.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            state_q <= IDLE;
            fw_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fill_last;
            if (cpu_wr) dirty_q[hit_way] <= 1'b1;
            if (fill_go) begin
                state_q         <= FILL;
                fw_q            <= victim;
                valid_q[victim] <= 1'b0;
                cnt_q           <= '0;
            end
            if (fill_beat) cnt_q <= cnt_q + OFF_BITS'(1);
            if (fill_last) begin
                valid_q[fw_q] <= 1'b1;
                dirty_q[fw_q] <= 1'b0;
                state_q       <= IDLE;
                cnt_q         <= '0;
            end
        end
    end

    cache_set_assoc_plru_tree #(.WAYS(WAYS)) u_plru (
        .CLK       (CLK),
        .Reset     (Reset),
        .TouchA    (touch_hit),
        .TouchWayA (hit_way),
        .TouchB    (fill_last),
        .TouchWayB (fw_q),
        .VictimWay (plru_victim)
    );

endmodule

// File: tb/tb_cache_set_assoc.sv
// Scoreboard bench for cache_set_assoc: expectations are queued as stimulus
// is applied and compared once the DUT outputs have settled.
module tb_cache_set_assoc;

    localparam int WAYS   = 4;
    localparam int WORDS  = 4;
    localparam int TAG_W  = 26;
    localparam int DATA_W = 32;

    localparam int S_HIT    = 0;
    localparam int S_WAY    = 1;
    localparam int S_RD     = 2;
    localparam int S_VIC    = 3;
    localparam int S_VDIRTY = 4;
    localparam int S_VTAG   = 5;
    localparam int S_BUSY   = 6;
    localparam int S_DONE   = 7;
    localparam int S_EVRD   = 8;

    typedef struct {
        string       name;
        int          sig;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic clk    = 1'b0;
    logic rst    = 1'b1;

    cache_set_assoc_if #(.WAYS(WAYS), .WORDS(WORDS), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus();

    cache_set_assoc #(.WAYS(WAYS), .WORDS(WORDS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            S_HIT:    return 64'(bus.Hit);
            S_WAY:    return 64'(bus.HitWay);
            S_RD:     return 64'(bus.RD);
            S_VIC:    return 64'(bus.VictimWay);
            S_VDIRTY: return 64'(bus.VictimDirty);
            S_VTAG:   return 64'(bus.VictimTag);
            S_BUSY:   return 64'(bus.FillBusy);
            S_DONE:   return 64'(bus.FillDone);
            S_EVRD:   return 64'(bus.EvictRD);
            default:  return 64'hDEAD_0000_0000_0000;
        endcase
    endfunction

    task automatic expect_sig(input string name, input int sig, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued.
    task automatic drain();
        exp_t e;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, observe(e.sig), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string name, input logic [TAG_W-1:0] tag, input int off,
                        input logic hit, input int way, input logic [DATA_W-1:0] rd);
        bus.ReqTag = tag;
        bus.Offset = 2'(off);
        expect_sig({name, "_hit"}, S_HIT, 64'(hit));
        if (hit) expect_sig({name, "_way"}, S_WAY, 64'(way));
        expect_sig({name, "_rd"}, S_RD, 64'(rd));
        drain();
    endtask

    task automatic start_fill(input string name, input logic [TAG_W-1:0] tag, input int way);
        bus.ReqTag = tag;
        expect_sig({name, "_vic_pre"}, S_VIC, 64'(way));
        drain();
        bus.FillStart = 1'b1;
        step();
        bus.FillStart = 1'b0;
        expect_sig({name, "_busy"}, S_BUSY, 64'd1);
        expect_sig({name, "_vic_hold"}, S_VIC, 64'(way));
        expect_sig({name, "_nohit"}, S_HIT, 64'd0);
        drain();
    endtask

    task automatic beat(input logic [DATA_W-1:0] d);
        bus.FillWE = 1'b1;
        bus.FillWD = d;
        step();
        bus.FillWE = 1'b0;
    endtask

    // Full line fill with one idle gap after the second beat.
    task automatic fill_line(input string name, input logic [TAG_W-1:0] tag,
                             input logic [DATA_W-1:0] base, input int way);
        start_fill(name, tag, way);
        for (int i = 0; i < WORDS; i++) begin
            beat(base + DATA_W'(i));
            if (i == 1) step();
            if (i < WORDS - 1) begin
                expect_sig({name, "_done_early"}, S_DONE, 64'd0);
                drain();
            end
        end
        expect_sig({name, "_done"}, S_DONE, 64'd1);
        expect_sig({name, "_busy_end"}, S_BUSY, 64'd0);
        drain();
        step();
        expect_sig({name, "_done_pulse"}, S_DONE, 64'd0);
        drain();
    endtask

    initial begin
        bus.Offset      = '0;
        bus.ReqTag      = '0;
        bus.Access      = 1'b0;
        bus.WE          = 1'b0;
        bus.WD          = '0;
        bus.EvictOffset = '0;
        bus.FillStart   = 1'b0;
        bus.FillWE      = 1'b0;
        bus.FillWD      = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // reset state
        bus.ReqTag = 26'h123;
        bus.Access = 1'b1;
        expect_sig("rst_hit", S_HIT, 64'd0);
        expect_sig("rst_rd", S_RD, 64'd0);
        expect_sig("rst_vic", S_VIC, 64'd0);
        expect_sig("rst_vdirty", S_VDIRTY, 64'd0);
        expect_sig("rst_busy", S_BUSY, 64'd0);
        expect_sig("rst_done", S_DONE, 64'd0);
        drain();
        bus.Access = 1'b0;

        // first fill into way 0, then lookup
        fill_line("f0", 26'h123, 32'hA0, 0);
        look("f0_rd", 26'h123, 2, 1'b1, 0, 32'hA2);

        // write hit
        bus.Offset = 2'd1;
        bus.Access = 1'b1;
        bus.WE     = 1'b1;
        bus.WD     = 32'hDEADBEEF;
        expect_sig("wr_hit", S_HIT, 64'd1);
        drain();
        step();
        bus.Access = 1'b0;
        bus.WE     = 1'b0;
        expect_sig("wr_rd", S_RD, 64'hDEADBEEF);
        expect_sig("wr_vic", S_VIC, 64'd1);
        drain();

        // miss write is ignored
        bus.ReqTag = 26'h777;
        bus.Access = 1'b1;
        bus.WE     = 1'b1;
        bus.WD     = 32'h1111;
        step();
        bus.Access = 1'b0;
        bus.WE     = 1'b0;
        look("miswr", 26'h123, 1, 1'b1, 0, 32'hDEADBEEF);

        // fill remaining ways; dirty way 0 becomes the victim
        fill_line("f1", 26'h200, 32'h200, 1);
        fill_line("f2", 26'h300, 32'h300, 2);
        fill_line("f3", 26'h400, 32'h400, 3);
        bus.EvictOffset = 2'd1;
        expect_sig("ev_vic", S_VIC, 64'd0);
        expect_sig("ev_dirty", S_VDIRTY, 64'd1);
        expect_sig("ev_tag", S_VTAG, 64'h123);
        expect_sig("ev_rd1", S_EVRD, 64'hDEADBEEF);
        drain();
        bus.EvictOffset = 2'd3;
        expect_sig("ev_rd3", S_EVRD, 64'hA3);
        drain();

        // PLRU ordering
        rst = 1'b1;
        step();
        rst = 1'b0;
        fill_line("p1", 26'd1, 32'h100, 0);
        fill_line("p2", 26'd2, 32'h200, 1);
        fill_line("p3", 26'd3, 32'h300, 2);
        fill_line("p4", 26'd4, 32'h400, 3);
        bus.Access = 1'b1;
        look("p_hit1", 26'd1, 0, 1'b1, 0, 32'h100);
        step();
        look("p_hit3", 26'd3, 1, 1'b1, 2, 32'h301);
        step();
        bus.Access = 1'b0;
        expect_sig("p_vic", S_VIC, 64'd1);
        expect_sig("p_vdirty", S_VDIRTY, 64'd0);
        drain();
        fill_line("p5", 26'd5, 32'h500, 1);
        look("p_miss2", 26'd2, 0, 1'b0, 0, 32'h0);
        look("p_hit5", 26'd5, 3, 1'b1, 1, 32'h503);
        look("p_hit1b", 26'd1, 2, 1'b1, 0, 32'h102);
        expect_sig("p_vic2", S_VIC, 64'd3);
        drain();

        // activity during a fill of way 2
        rst = 1'b1;
        step();
        rst = 1'b0;
        fill_line("c0", 26'h10, 32'h1000, 0);
        fill_line("c1", 26'h11, 32'h1100, 1);
        start_fill("c2", 26'h22, 2);
        beat(32'h2200);
        bus.ReqTag = 26'h10;
        bus.Offset = 2'd3;
        bus.Access = 1'b1;
        bus.WE     = 1'b1;
        bus.WD     = 32'h55;
        bus.FillWE = 1'b1;
        bus.FillWD = 32'h2201;
        expect_sig("c_hit0", S_HIT, 64'd1);
        expect_sig("c_way0", S_WAY, 64'd0);
        expect_sig("c_rd0", S_RD, 64'h1003);
        drain();
        step();
        bus.Access = 1'b0;
        bus.WE     = 1'b0;
        bus.FillWE = 1'b0;
        look("c_wr0", 26'h10, 3, 1'b1, 0, 32'h55);
        look("c_fillmiss", 26'h22, 0, 1'b0, 0, 32'h0);
        bus.ReqTag    = 26'h33;
        bus.FillStart = 1'b1;
        step();
        bus.FillStart = 1'b0;
        expect_sig("c_ign_busy", S_BUSY, 64'd1);
        expect_sig("c_ign_vic", S_VIC, 64'd2);
        drain();
        beat(32'h2202);
        beat(32'h2203);
        expect_sig("c_done", S_DONE, 64'd1);
        expect_sig("c_busy_end", S_BUSY, 64'd0);
        drain();
        look("c_hit2a", 26'h22, 1, 1'b1, 2, 32'h2201);
        look("c_hit2b", 26'h22, 3, 1'b1, 2, 32'h2203);
        look("c_miss33", 26'h33, 0, 1'b0, 0, 32'h0);

        // reset in the middle of a fill
        start_fill("r3", 26'h44, 3);
        beat(32'h4400);
        beat(32'h4401);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_sig("r_busy", S_BUSY, 64'd0);
        expect_sig("r_vic", S_VIC, 64'd0);
        expect_sig("r_done", S_DONE, 64'd0);
        drain();
        look("r_miss44", 26'h44, 0, 1'b0, 0, 32'h0);
        look("r_miss10", 26'h10, 0, 1'b0, 0, 32'h0);
        fill_line("r0", 26'h44, 32'h4400, 0);
        look("r_hit44", 26'h44, 2, 1'b1, 0, 32'h4402);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_set_assoc.md
Name: cache_set_assoc

Overview:
- Parametrised N-way set-associative cache set, the successor to the single-line cache block.
- Holds WAYS lines of WORDS words each, with per-way Valid/Dirty/Tag.
- Performs parallel tag compare and tree-PLRU replacement.
- Runs a counter-driven line-fill sequence; sits in the MIPS pipeline data-cache datapath under the cache controller FSM.

Parameters:
- WAYS, 4, number of ways; power of two, 2..8.
- WORDS, 4, words per line; power of two, 2..16.
- TAG_W, 26, tag width.
- DATA_W, 32, word width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Offset  in  log2(WORDS)  word offset for CPU access.
- ReqTag  in  TAG_W  request tag.
- Access  in  1  CPU access strobe; qualifies PLRU touch and WE.
- WE  in  1  CPU write; effective only when Access and Hit are both 1.
- WD  in  DATA_W  CPU write data.
- Hit  out  1  some valid way's tag equals ReqTag.
- HitWay  out  log2(WAYS)  index of the hitting way.
- RD  out  DATA_W  data[HitWay][Offset]; 0 when Hit=0.
- VictimWay  out  log2(WAYS)  replacement candidate.
- VictimDirty  out  1  dirty & valid of the victim.
- VictimTag  out  TAG_W  tag of the victim.
- EvictOffset  in  log2(WORDS)  word select for write-back read.
- EvictRD  out  DATA_W  data[VictimWay][EvictOffset].
- FillStart  in  1  begin a line fill into VictimWay using ReqTag.
- FillWE  in  1  one fill beat valid.
- FillWD  in  DATA_W  fill beat data.
- FillBusy  out  1  fill in progress.
- FillDone  out  1  one-cycle pulse on the cycle after the last beat is written.

Behaviour:
- Reset:
  - All Valid, dirty and PLRU bits clear to 0; FillBusy=0, FillDone=0, fill counter=0.
  - Data and tag arrays are not reset.
  - Post-reset outputs: Hit=0, RD=0, VictimWay=0, VictimDirty=0.
  - Reset mid-fill aborts the fill; the target way stays invalid.
- Lookup is combinational, 0-cycle latency: Hit, HitWay and RD follow Offset and ReqTag in the same cycle.
  - Only one way can match. A way matches when its Valid=1 and its tag equals ReqTag.
- CPU write: when Access & Hit & WE, then at posedge data[HitWay][Offset]<=WD and dirty[HitWay]<=1.
  - WE on a miss is ignored with no state change.
- PLRU:
  - Binary tree with WAYS-1 bits. Bit=0 means the victim lies in the left subtree.
  - Touch(way) sets the path bits to point away from that way.
  - Access & Hit touches HitWay.
  - Fill completion touches the filled way. If both touches occur in one cycle, apply the hit touch first, then the fill touch.
- Victim selection:
  - The lowest-index invalid way if any way is invalid; otherwise the PLRU victim.
  - While FillBusy=1, VictimWay is held at the latched fill way.
- Fill FSM, states IDLE and FILL:
  - IDLE --FillStart--> FILL. On this transition: latch fw=VictimWay, Valid[fw]<=0, tag[fw]<=ReqTag, counter<=0.
  - In FILL, each FillWE writes data[fw][counter]<=FillWD and increments counter.
  - On the beat with counter==WORDS-1: Valid[fw]<=1, dirty[fw]<=0, PLRU touch of fw, return to IDLE. FillDone pulses on the following cycle.
  - FillWE in IDLE is ignored. FillStart in FILL is ignored.
  - Beats need not be consecutive; idle cycles between them are allowed.
  - Counter wraps to 0 at completion.
- During FILL, the fill way is invalid and cannot hit. Other ways hit, are written and are touched normally.
- VictimDirty and VictimTag reflect state before FillStart takes effect, so the controller must read them and drain the victim before asserting FillStart.

Decomposition:
- cache_pkg holds:
  - a clog2 function;
  - the localparams OFF_W=clog2(WORDS) and WAY_W=clog2(WAYS);
  - the fill-state encoding (IDLE=1'b0, FILL=1'b1).
- One sub-module, plru_tree, parametrised by WAYS.
  - Inputs: CLK, Reset, TouchA/TouchWayA, TouchB/TouchWayB (B applied after A).
  - Output: VictimWay.
- Tag compare and arrays stay in the top module.

Test Plan:
- Reset, then ReqTag=0x0000123, Access=1 -> Hit=0, VictimWay=0, FillBusy=0.
- Fill way 0:
  - Stimulus: FillStart with ReqTag=0x0000123, then 4 beats of FillWD=0xA0..0xA3 with one idle gap.
  - Required: FillDone pulses one cycle after the 4th beat.
  - Then Offset=2 -> Hit=1, HitWay=0, RD=0xA2.
- Write hit: Access=1, WE=1, Offset=1, WD=0xDEADBEEF on tag 0x123 -> RD=0xDEADBEEF next cycle.
  - After filling all 4 ways, evicting way 0 shows VictimDirty=1 and VictimTag=0x123.
- PLRU with WAYS=4:
  - Fill tags 1,2,3,4 into ways 0..3, then hit tag 1 and tag 3.
  - Required: VictimWay=1; a new fill of tag 5 replaces way 1, and tag 2 then misses.
- Concurrent activity during a fill of way 2: hits on way 0 return correct data; ReqTag equal to the fill tag gives Hit=0 until the fill completes; FillStart mid-fill is ignored.
- Reset after 2 of 4 fill beats -> FillBusy=0, all Hit=0, VictimWay=0; a subsequent full fill succeeds.
